// File: rtl/inv_mix_columns.sv
// AES inverse MixColumns as an elastic valid/ready pipeline.
// MID_REG=1 registers the per-byte xtime multiples before the column combine.
module inv_mix_columns #(
  parameter int MID_REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [127:0] state_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [127:0] state_o
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0]   m1 [16];
  logic [7:0]   m2 [16];
  logic [7:0]   m4 [16];
  logic [7:0]   m8 [16];
  logic [7:0]   c_m1 [16];
  logic [7:0]   c_m2 [16];
  logic [7:0]   c_m4 [16];
  logic [7:0]   c_m8 [16];
  logic         src_valid;
  logic         out_adv;
  logic [127:0] res;

  assign out_adv = !valid_o || ready_i;

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      m1[i] = state_i[127-8*i -: 8];
      m2[i] = xtime(m1[i]);
      m4[i] = xtime(m2[i]);
      m8[i] = xtime(m4[i]);
    end
  end

  generate
    if (MID_REG != 0) begin : g_mid
      logic       s1_valid;
      logic       s1_adv;
      logic [7:0] s1_m1 [16];
      logic [7:0] s1_m2 [16];
      logic [7:0] s1_m4 [16];
      logic [7:0] s1_m8 [16];

      assign s1_adv  = !s1_valid || out_adv;
      assign ready_o = !rst && s1_adv;
      assign src_valid = s1_valid;
      assign c_m1 = s1_m1;
      assign c_m2 = s1_m2;
      assign c_m4 = s1_m4;
      assign c_m8 = s1_m8;

      always_ff @(posedge clk) begin
        if (rst) begin
          s1_valid <= 1'b0;
          for (int i = 0; i < 16; i++) begin
            s1_m1[i] <= '0;
            s1_m2[i] <= '0;
            s1_m4[i] <= '0;
            s1_m8[i] <= '0;
          end
        end else if (s1_adv) begin
          s1_valid <= valid_i;
          if (valid_i) begin
            for (int i = 0; i < 16; i++) begin
              s1_m1[i] <= m1[i];
              s1_m2[i] <= m2[i];
              s1_m4[i] <= m4[i];
              s1_m8[i] <= m8[i];
            end
          end
        end
      end
    end else begin : g_flat
      assign ready_o   = !rst && out_adv;
      assign src_valid = valid_i;
      assign c_m1 = m1;
      assign c_m2 = m2;
      assign c_m4 = m4;
      assign c_m8 = m8;
    end
  endgenerate

  // Row r of a column sees coefficients 14,11,13,9 starting at byte r, rotating.
  always_comb begin
    int j0, j1, j2, j3;
    j0 = 0;
    j1 = 0;
    j2 = 0;
    j3 = 0;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        j0 = 4*c + r;
        j1 = 4*c + ((r + 1) % 4);
        j2 = 4*c + ((r + 2) % 4);
        j3 = 4*c + ((r + 3) % 4);
        res[127-8*(4*c+r) -: 8] = (c_m8[j0] ^ c_m4[j0] ^ c_m2[j0])
                                ^ (c_m8[j1] ^ c_m2[j1] ^ c_m1[j1])
                                ^ (c_m8[j2] ^ c_m4[j2] ^ c_m1[j2])
                                ^ (c_m8[j3] ^ c_m1[j3]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o <= 1'b0;
      state_o <= '0;
    end else if (out_adv) begin
      valid_o <= src_valid;
      if (src_valid) state_o <= res;
    end
  end

endmodule

// File: tb/tb_inv_mix_columns.sv
// Bench for inv_mix_columns: MID_REG=1 and MID_REG=0 instances checked against
// a GF(2^8) matrix model built on polynomial multiply-and-reduce.
module tb_inv_mix_columns;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         valid_i, ready_i, ready_o, valid_o;
  logic [127:0] state_i, state_o;
  logic         valid0_i, ready0_i, ready0_o, valid0_o;
  logic [127:0] state0_i, state0_o;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [127:0] VEC_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] VEC_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;

  inv_mix_columns #(.MID_REG(1)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .state_i(state_i),
    .valid_o(valid_o), .ready_i(ready_i), .state_o(state_o)
  );

  inv_mix_columns #(.MID_REG(0)) dut0 (
    .clk(clk), .rst(rst), .valid_i(valid0_i), .ready_o(ready0_o), .state_i(state0_i),
    .valid_o(valid0_o), .ready_i(ready0_i), .state_o(state0_o)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'(9'h11b) << (i - 8));
    return p[7:0];
  endfunction

  // Circulant matrix with first row coefs applied to each column.
  function automatic logic [127:0] mat_apply(input logic [127:0] s, input logic [31:0] coefs);
    logic [127:0] r;
    logic [7:0]   acc;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        acc = '0;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(coefs[31-8*((k-row+4)%4) -: 8], s[127-8*(4*c+k) -: 8]);
        r[127-8*(4*c+row) -: 8] = acc;
      end
    return r;
  endfunction

  function automatic logic [127:0] inv_model(input logic [127:0] s);
    return mat_apply(s, 32'h0e0b0d09);
  endfunction

  function automatic logic [127:0] mix_model(input logic [127:0] s);
    return mat_apply(s, 32'h02030101);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    valid_i = 1'b1; ready_i = 1'b0; state_i = rand128();
    valid0_i = 1'b1; ready0_i = 1'b0; state0_i = rand128();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_tests++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid_o: got %b want 0", valid_o); end
    n_tests++; if (state_o !== 128'h0) begin n_fail++; $display("FAIL reset_state_o: got %h want 0", state_o); end
    n_tests++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready_o: got %b want 0", ready_o); end
    n_tests++; if (valid0_o !== 1'b0 || ready0_o !== 1'b0) begin n_fail++; $display("FAIL reset_mid0: got valid=%b ready=%b want 0 0", valid0_o, ready0_o); end
    rst = 1'b0; valid_i = 1'b0; ready_i = 1'b1; valid0_i = 1'b0; ready0_i = 1'b1;
    #1;
    n_tests++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", ready_o); end
  endtask

  task automatic test_single_vector();
    int lat = -1, hits = 0;
    @(negedge clk); valid_i = 1'b1; state_i = VEC_IN; ready_i = 1'b1; #1;
    n_tests++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL vec_accept: got ready_o=%b want 1", ready_o); end
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk); valid_i = 1'b0; #1;
      if (valid_o) begin
        if (lat < 0) lat = cyc;
        hits++;
        n_tests++; if (state_o !== VEC_OUT) begin n_fail++; $display("FAIL vec_data: got %h want %h", state_o, VEC_OUT); end
      end
    end
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL vec_latency: got %0d want 2", lat); end
    n_tests++; if (hits != 1) begin n_fail++; $display("FAIL vec_pulses: got %0d want 1", hits); end
  endtask

  task automatic test_streaming();
    logic [127:0] exp_q[$];
    int sent = 0, got = 0, first = -1, last = -1, drops = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      ready_i = 1'b1;
      if (sent < 9) begin valid_i = 1'b1; state_i = rand128(); end else valid_i = 1'b0;
      #1;
      if (valid_o) begin
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL stream_extra: got %h want none", state_o); end
        else begin
          logic [127:0] e;
          e = exp_q.pop_front();
          if (state_o !== e) begin n_fail++; $display("FAIL stream_data: got %h want %h", state_o, e); end
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      if (valid_i && !ready_o) drops++;
      if (valid_i && ready_o) begin exp_q.push_back(inv_model(state_i)); sent++; end
    end
    valid_i = 1'b0;
    n_tests++; if (got != 9) begin n_fail++; $display("FAIL stream_count: got %0d want 9", got); end
    n_tests++; if (last - first != 8) begin n_fail++; $display("FAIL stream_gapless: got span %0d want 8", last - first); end
    n_tests++; if (drops != 0) begin n_fail++; $display("FAIL stream_ready_drop: got %0d drops want 0", drops); end
  endtask

  task automatic test_backpressure();
    logic [127:0] ins[5];
    logic [127:0] exp_q[$];
    logic [127:0] held;
    int idx = 0, got = 0, unstable = 0;
    bit held_set = 0;
    logic last_ready;
    for (int i = 0; i < 5; i++) ins[i] = rand128() ^ 128'(i);
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk); ready_i = 1'b0; valid_i = 1'b1; state_i = ins[idx]; #1;
      if (valid_o) begin
        if (!held_set) begin held = state_o; held_set = 1; end
        else if (state_o !== held) unstable++;
      end
      last_ready = ready_o;
      if (valid_i && ready_o) begin exp_q.push_back(inv_model(state_i)); idx++; end
    end
    n_tests++; if (idx != 2) begin n_fail++; $display("FAIL bp_accepts: got %0d want 2", idx); end
    n_tests++; if (last_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b want 0", last_ready); end
    n_tests++; if (!held_set || held !== inv_model(ins[0])) begin n_fail++; $display("FAIL bp_held: got %h want %h", held, inv_model(ins[0])); end
    n_tests++; if (unstable != 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes want 0", unstable); end
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk); ready_i = 1'b1;
      valid_i = (idx < 5);
      state_i = (idx < 5) ? ins[idx] : '0;
      #1;
      if (valid_o) begin
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL bp_extra: got %h want none", state_o); end
        else begin
          logic [127:0] e;
          e = exp_q.pop_front();
          if (state_o !== e) begin n_fail++; $display("FAIL bp_order: got %h want %h", state_o, e); end
        end
        got++;
      end
      if (valid_i && ready_o) begin exp_q.push_back(inv_model(state_i)); idx++; end
    end
    valid_i = 1'b0;
    n_tests++; if (got != 5) begin n_fail++; $display("FAIL bp_count: got %0d want 5", got); end
  endtask

  task automatic test_random();
    logic [127:0] exp_q[$];
    logic [127:0] x;
    int sent = 0, got = 0;
    x = rand128();
    for (int cyc = 0; cyc < 3000 && got < 200; cyc++) begin
      @(negedge clk);
      ready_i = 1'($urandom_range(0, 1));
      valid_i = (sent < 200) && ($urandom_range(0, 1) == 1);
      state_i = mix_model(x);
      #1;
      if (valid_o && ready_i) begin
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL rand_extra: got %h want none", state_o); end
        else begin
          logic [127:0] e;
          e = exp_q.pop_front();
          if (state_o !== e) begin n_fail++; $display("FAIL rand_roundtrip: got %h want %h", state_o, e); end
        end
        got++;
      end
      if (valid_i && ready_o) begin exp_q.push_back(x); sent++; x = rand128(); end
    end
    valid_i = 1'b0; ready_i = 1'b1;
    n_tests++; if (got != 200) begin n_fail++; $display("FAIL rand_count: got %0d want 200", got); end
  endtask

  task automatic test_reset_midstream();
    logic [127:0] c_in;
    int stale = 0, hits = 0, lat = -1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); ready_i = 1'b0; valid_i = 1'b1; state_i = rand128();
    end
    @(negedge clk); valid_i = 1'b0; rst = 1'b1;
    @(negedge clk); #1;
    n_tests++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", valid_o); end
    n_tests++; if (state_o !== 128'h0) begin n_fail++; $display("FAIL rstmid_state: got %h want 0", state_o); end
    rst = 1'b0; ready_i = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk); #1;
      if (valid_o) stale++;
    end
    n_tests++; if (stale != 0) begin n_fail++; $display("FAIL rstmid_stale: got %0d outputs want 0", stale); end
    c_in = rand128();
    @(negedge clk); valid_i = 1'b1; state_i = c_in; #1;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk); valid_i = 1'b0; #1;
      if (valid_o) begin
        hits++;
        if (lat < 0) lat = cyc;
        n_tests++; if (state_o !== inv_model(c_in)) begin n_fail++; $display("FAIL rstmid_data: got %h want %h", state_o, inv_model(c_in)); end
      end
    end
    n_tests++; if (hits != 1 || lat != 2) begin n_fail++; $display("FAIL rstmid_post: got %0d outputs lat %0d want 1 lat 2", hits, lat); end
  endtask

  task automatic test_mid0_vector();
    int lat = -1, hits = 0;
    @(negedge clk); valid0_i = 1'b1; state0_i = VEC_IN; ready0_i = 1'b1; #1;
    n_tests++; if (ready0_o !== 1'b1) begin n_fail++; $display("FAIL mid0_accept: got %b want 1", ready0_o); end
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk); valid0_i = 1'b0; #1;
      if (valid0_o) begin
        hits++;
        if (lat < 0) lat = cyc;
        n_tests++; if (state0_o !== VEC_OUT) begin n_fail++; $display("FAIL mid0_data: got %h want %h", state0_o, VEC_OUT); end
      end
    end
    n_tests++; if (hits != 1 || lat != 1) begin n_fail++; $display("FAIL mid0_latency: got %0d outputs lat %0d want 1 lat 1", hits, lat); end
  endtask

  task automatic test_mid0_stream_stall();
    logic [127:0] ins[10];
    logic [127:0] exp_q[$];
    int idx = 0, got = 0, drops = 0, stall_acc = 0;
    logic last_ready;
    for (int i = 0; i < 10; i++) ins[i] = rand128();
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk); ready0_i = 1'b1; valid0_i = 1'b1; state0_i = ins[idx]; #1;
      if (valid0_o) begin
        n_tests++; got++;
        if (exp_q.size() == 0 || state0_o !== exp_q[0]) begin n_fail++; $display("FAIL mid0_stream: got %h want %h", state0_o, exp_q.size() ? exp_q[0] : 128'h0); end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (!ready0_o) drops++;
      if (ready0_o) begin exp_q.push_back(inv_model(state0_i)); idx++; end
    end
    n_tests++; if (drops != 0 || got != 5) begin n_fail++; $display("FAIL mid0_throughput: got drops %0d outputs %0d want 0 5", drops, got); end
    @(negedge clk); valid0_i = 1'b0; #1;
    if (valid0_o) begin
      n_tests++; got++;
      if (exp_q.size() == 0 || state0_o !== exp_q[0]) begin n_fail++; $display("FAIL mid0_stream: got %h want %h", state0_o, exp_q.size() ? exp_q[0] : 128'h0); end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk); ready0_i = 1'b0; valid0_i = 1'b1; state0_i = ins[idx]; #1;
      last_ready = ready0_o;
      if (ready0_o) begin exp_q.push_back(inv_model(state0_i)); idx++; stall_acc++; end
    end
    n_tests++; if (stall_acc != 1) begin n_fail++; $display("FAIL mid0_capacity: got %0d accepts want 1", stall_acc); end
    n_tests++; if (last_ready !== 1'b0) begin n_fail++; $display("FAIL mid0_ready_low: got %b want 0", last_ready); end
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk); ready0_i = 1'b1; valid0_i = (idx < 10); state0_i = (idx < 10) ? ins[idx] : '0; #1;
      if (valid0_o) begin
        n_tests++; got++;
        if (exp_q.size() == 0 || state0_o !== exp_q[0]) begin n_fail++; $display("FAIL mid0_drain: got %h want %h", state0_o, exp_q.size() ? exp_q[0] : 128'h0); end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (valid0_i && ready0_o) begin exp_q.push_back(inv_model(state0_i)); idx++; end
    end
    valid0_i = 1'b0;
    n_tests++; if (got != 10) begin n_fail++; $display("FAIL mid0_count: got %0d want 10", got); end
  endtask

  initial begin
    test_reset();
    test_single_vector();
    test_streaming();
    test_backpressure();
    test_random();
    test_reset_midstream();
    test_mid0_vector();
    test_mid0_stream_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
